program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows (clock and reset first):
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  8  byte-stream payload.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- cpu_input  out  8  byte presented to the CPU load port.
- load_address  out  5  CPU memory address for cpu_input.
- load  out  1  one-cycle write strobe to the CPU.
- is_instruction  out  1  1 = instruction memory, 0 = data memory.
- cpu_run  out  1  1 = CPU released to execute.
- frame_done  out  1  one-cycle pulse at end of a good load frame.
- err  out  1  sticky protocol error.

Function
REQ-002 The block SHALL act as the driving end of the CPU load port, converting a byte stream into load strobes.
REQ-003 Frame format SHALL be: CMD, LEN, then LEN payload bytes, then a checksum byte if configured (see REQ-018).
- CMD[7] = is_instruction, CMD[6:5] = 00, CMD[4:0] = start address.
- LEN = payload count, 1..32.
REQ-004 CMD 0xFF SHALL be RUN: cpu_run = 1 from the next cycle. CMD 0xFE SHALL be HALT: cpu_run = 0 from the next cycle. Neither has a LEN byte.
REQ-005 The FSM SHALL use states S_CMD, S_LEN, S_DATA, S_CSUM and S_ERR:
- S_CMD -> S_LEN on a load CMD; stays in S_CMD on RUN or HALT.
- S_LEN -> S_DATA on a valid LEN.
- S_DATA -> S_CSUM (if configured) or S_CMD after the last payload byte.
- S_CSUM -> S_CMD.
REQ-006 in_ready SHALL be 1 in every state except S_ERR, where it is 0.
REQ-007 A payload byte accepted in cycle N SHALL produce, in cycle N+1, load = 1, cpu_input = the byte, load_address = (start + index) mod 32, and is_instruction = CMD[7].
REQ-008 load SHALL be high for exactly one cycle per payload byte.
- Back-to-back accepts SHALL give consecutive load cycles.
- cpu_input, load_address and is_instruction SHALL hold their values while load = 0.
REQ-009 Address SHALL wrap from 31 to 0 within a frame.
REQ-010 frame_done SHALL pulse for one cycle, the cycle after the final byte of a frame is accepted, and only if no error occurred in that frame.
REQ-011 The following SHALL be errors: CMD[6:5] != 00 (other than 0xFE/0xFF), LEN = 0, LEN > 32, and a load CMD while cpu_run = 1.
- On any error the FSM SHALL enter S_ERR and set err = 1 the next cycle.
- No load strobe SHALL be issued for the offending byte.
REQ-012 S_ERR SHALL be left only by reset; err and cpu_run SHALL hold their values while in S_ERR.
REQ-013 Payload loads already issued before an error SHALL NOT be retracted.

Reset
REQ-014 Asserting reset SHALL asynchronously force the following, regardless of any frame in progress:
- state = S_CMD, in_ready = 1.
- load = 0, frame_done = 0, err = 0, cpu_run = 0.
- cpu_input = 0x00, load_address = 0, is_instruction = 0.
REQ-015 Reset asserted mid-frame SHALL discard the partial frame; the first byte accepted after deassertion SHALL be decoded as a CMD.

Configuration
REQ-016 Macro PROGRAM_LOADER_CHECKSUM_EN SHALL select checksum support.
REQ-017 Without the macro, the frame SHALL end after the last payload byte and S_CSUM SHALL be absent.
REQ-018 With the macro, one checksum byte SHALL follow the payload.
- (CMD + LEN + payload + checksum) mod 256 SHALL equal 0.
- On a mismatch the FSM SHALL go to S_ERR with err = 1 and frame_done SHALL NOT pulse.
- frame_done SHALL pulse the cycle after a correct checksum is accepted.

Structure
REQ-019 Shared package program_loader_pkg SHALL hold:
- the state enum;
- CMD_RUN = 8'hFF and CMD_HALT = 8'hFE;
- MAX_LEN = 32, ADDR_W = 5, DATA_W = 8.
REQ-020 A single sub-module, loader_checksum (running 8-bit sum, clear and add inputs), SHALL exist and SHALL be instantiated only under PROGRAM_LOADER_CHECKSUM_EN.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Instruction frame 0x80, 0x02, 0x01, 0x02 (plus checksum 0x7B if enabled) -> load pulses at addresses 0 and 1 with values 0x01 and 0x02, is_instruction = 1, then one frame_done pulse.
- Data frame 0x1F, 0x02, 0x0F, 0xAA -> loads at address 31 then address 0 (wrap), is_instruction = 0.
- Error inputs LEN = 0x00 and LEN = 0x21, each after a valid CMD -> err = 1, in_ready = 0, no load pulse, state persists until reset.
- Sequence 0xFF, then load CMD 0x00 -> cpu_run = 1, then err = 1; a following 0xFE is ignored because the FSM is in S_ERR.
- Reset pulse after 1 of 3 payload bytes, then a new frame 0x05, 0x01, 0x33 -> load_address = 5, cpu_input = 0x33, err = 0.
- With the macro enabled, a bad checksum -> err = 1 and no frame_done pulse.

Source files
------------

// File: rtl/program_loader_pkg.sv
// ============================================================================
// Module   : program_loader_pkg
// Brief    : Shared constants and FSM state type for the program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package program_loader_pkg;

  localparam int MAX_LEN = 32;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 8;

  localparam logic [DATA_W-1:0] CMD_RUN  = 8'hFF;
  localparam logic [DATA_W-1:0] CMD_HALT = 8'hFE;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_LEN  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_ERR  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/program_loader_if.sv
// ============================================================================
// Module   : program_loader_if
// Brief    : Byte-stream input and CPU load-port bundle for the program loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface program_loader_if;
  import program_loader_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] cpu_input;
  logic [ADDR_W-1:0] load_address;
  logic              load;
  logic              is_instruction;
  logic              cpu_run;
  logic              frame_done;
  logic              err;

  modport master (
    output in_data, in_valid,
    input  in_ready, cpu_input, load_address, load, is_instruction,
           cpu_run, frame_done, err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, cpu_input, load_address, load, is_instruction,
           cpu_run, frame_done, err
  );

endinterface

`default_nettype wire

// File: rtl/loader_checksum.sv
// ============================================================================
// Module   : loader_checksum
// Brief    : Running modulo-256 byte sum; clear with add restarts the sum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module loader_checksum
  import program_loader_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_clear,
  input  wire logic              i_add,
  input  wire logic [DATA_W-1:0] i_data,
  output logic      [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= i_add ? i_data : '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module   : program_loader
// Brief    : Decodes CMD/LEN/payload byte frames into CPU load strobes.
//            Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing checksum.
// Revision : 1.0
// ============================================================================
`default_nettype none

module program_loader
  import program_loader_pkg::*;
(
  input  wire logic      clk,
  input  wire logic      reset,
  program_loader_if.slave bus
);

  localparam logic [DATA_W-1:0] c_max_len = 8'(MAX_LEN);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_frame_instr;
  logic [ADDR_W-1:0] r_addr;
  logic [5:0]        r_remaining;
  logic [DATA_W-1:0] r_cpu_input;
  logic [ADDR_W-1:0] r_load_address;
  logic              r_is_instruction;
  logic              r_load;
  logic              r_frame_done;
  logic              r_err;
  logic              r_cpu_run;

  logic w_accept, w_is_run, w_is_halt, w_cmd_bad, w_len_bad, w_last;
  logic w_in_ready, w_issue_load, w_issue_done, w_raise_err, w_run_set, w_run_clr;

  assign w_accept  = bus.in_valid && w_in_ready;
  assign w_is_run  = (bus.in_data == CMD_RUN);
  assign w_is_halt = (bus.in_data == CMD_HALT);
  // A load command is refused while the CPU is executing.
  assign w_cmd_bad = (bus.in_data[6:5] != 2'b00) || r_cpu_run;
  assign w_len_bad = (bus.in_data == '0) || (bus.in_data > c_max_len);
  assign w_last    = (r_remaining == 6'd1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] w_sum;
  logic              w_csum_ok;
  logic              w_csum_clear;
  logic              w_csum_add;

  assign w_csum_clear = w_accept && (r_state == S_CMD);
  assign w_csum_add   = w_accept;
  assign w_csum_ok    = ((w_sum + bus.in_data) == 8'd0);

  loader_checksum u_checksum (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_csum_clear),
    .i_add   (w_csum_add),
    .i_data  (bus.in_data),
    .o_sum   (w_sum)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_CMD;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CMD: begin
        if (w_accept && !w_is_run && !w_is_halt) begin
          w_next_state = w_cmd_bad ? S_ERR : S_LEN;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          w_next_state = w_len_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && w_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          w_next_state = S_CSUM;
`else
          w_next_state = S_CMD;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          w_next_state = w_csum_ok ? S_CMD : S_ERR;
        end
      end
`endif
      S_ERR:   w_next_state = S_ERR;
      default: w_next_state = S_CMD;
    endcase
  end

  always_comb begin
    w_in_ready   = (r_state != S_ERR);
    w_issue_load = w_accept && (r_state == S_DATA);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    w_issue_done = w_accept && (r_state == S_CSUM) && w_csum_ok;
`else
    w_issue_done = w_accept && (r_state == S_DATA) && w_last;
`endif
    w_raise_err  = (r_state != S_ERR) && (w_next_state == S_ERR);
    w_run_set    = w_accept && (r_state == S_CMD) && w_is_run;
    w_run_clr    = w_accept && (r_state == S_CMD) && w_is_halt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_instr    <= 1'b0;
      r_addr           <= '0;
      r_remaining      <= '0;
      r_cpu_input      <= '0;
      r_load_address   <= '0;
      r_is_instruction <= 1'b0;
      r_load           <= 1'b0;
      r_frame_done     <= 1'b0;
      r_err            <= 1'b0;
      r_cpu_run        <= 1'b0;
    end else begin
      r_load       <= w_issue_load;
      r_frame_done <= w_issue_done;
      if (w_raise_err) begin
        r_err <= 1'b1;
      end
      if (w_run_set) begin
        r_cpu_run <= 1'b1;
      end else if (w_run_clr) begin
        r_cpu_run <= 1'b0;
      end
      if (w_accept && (r_state == S_CMD)) begin
        r_frame_instr <= bus.in_data[7];
        r_addr        <= bus.in_data[ADDR_W-1:0];
      end
      if (w_accept && (r_state == S_LEN)) begin
        r_remaining <= bus.in_data[5:0];
      end
      // Load-port outputs only change on a strobe so they hold between loads.
      if (w_issue_load) begin
        r_cpu_input      <= bus.in_data;
        r_load_address   <= r_addr;
        r_is_instruction <= r_frame_instr;
        r_addr           <= r_addr + 5'd1;
        r_remaining      <= r_remaining - 6'd1;
      end
    end
  end

  assign bus.in_ready       = w_in_ready;
  assign bus.cpu_input      = r_cpu_input;
  assign bus.load_address   = r_load_address;
  assign bus.load           = r_load;
  assign bus.is_instruction = r_is_instruction;
  assign bus.cpu_run        = r_cpu_run;
  assign bus.frame_done     = r_frame_done;
  assign bus.err            = r_err;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module   : tb_program_loader
// Brief    : Directed and random frames checked against a frame-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;
  import program_loader_pkg::*;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  program_loader_if bus ();

  program_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    checks   = 0;
  int    failures = 0;
  string scen     = "reset";

  // Expected DUT outputs for the cycle after the most recent clock edge.
  logic       e_load, e_instr, e_run, e_done, e_err, e_ready;
  logic [7:0] e_cpu_input;
  logic [4:0] e_addr;

  // Frame position: 0 = expecting CMD, 1 = LEN, 2.. = payload, then checksum.
  int         m_pos, m_len, m_sum;
  logic [7:0] m_cmd;
  bit         m_err;

  logic [7:0] fr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=0x%0h expected=0x%0h", scen, tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("in_ready",       32'(bus.in_ready),       32'(e_ready));
    chk("load",           32'(bus.load),           32'(e_load));
    chk("cpu_input",      32'(bus.cpu_input),      32'(e_cpu_input));
    chk("load_address",   32'(bus.load_address),   32'(e_addr));
    chk("is_instruction", 32'(bus.is_instruction), 32'(e_instr));
    chk("cpu_run",        32'(bus.cpu_run),        32'(e_run));
    chk("frame_done",     32'(bus.frame_done),     32'(e_done));
    chk("err",            32'(bus.err),            32'(e_err));
  endtask

  task automatic model_reset();
    e_load = 0; e_instr = 0; e_run = 0; e_done = 0; e_err = 0; e_ready = 1;
    e_cpu_input = 8'h00; e_addr = 5'd0;
    m_pos = 0; m_len = 0; m_sum = 0; m_cmd = 8'h00; m_err = 0;
  endtask

  task automatic flag_err();
    m_err = 1; e_err = 1; e_ready = 0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    int idx;
    if (m_pos == 0) begin
      if (d == 8'hFF) e_run = 1;
      else if (d == 8'hFE) e_run = 0;
      else if (d[6:5] != 2'b00 || e_run) flag_err();
      else begin m_cmd = d; m_sum = int'(d); m_pos = 1; end
    end else if (m_pos == 1) begin
      if (d == 8'h00 || d > 8'd32) flag_err();
      else begin m_len = int'(d); m_sum += int'(d); m_pos = 2; end
    end else if (m_pos - 2 < m_len) begin
      idx = m_pos - 2;
      e_load = 1; e_cpu_input = d; e_instr = m_cmd[7];
      e_addr = 5'((int'(m_cmd[4:0]) + idx) % 32);
      m_sum += int'(d);
      m_pos++;
      if (m_pos - 2 == m_len && !CSUM) begin e_done = 1; m_pos = 0; end
    end else begin
      if ((m_sum + int'(d)) % 256 == 0) e_done = 1;
      else flag_err();
      m_pos = 0;
    end
  endtask

  // One clock cycle: check what the previous edge produced, then drive this cycle.
  task automatic step(input bit v, input logic [7:0] d);
    @(negedge clk);
    check_outputs();
    bus.in_valid = v;
    bus.in_data  = d;
    e_load = 0;
    e_done = 0;
    if (v && e_ready) model_byte(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #2;
    model_reset();
    check_outputs();
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic add_csum();
    int s = 0;
    foreach (fr[i]) s += int'(fr[i]);
    if (CSUM) fr.push_back(8'((256 - (s % 256)) % 256));
  endtask

  task automatic send(input bit gaps);
    foreach (fr[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 8'($urandom));
      step(1'b1, fr[i]);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 8'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, len;
    logic [7:0] cmd;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    model_reset();
    @(posedge clk);
    #1 check_outputs();
    #1 reset = 1'b0;

    scen = "instr_frame";
    fr = '{8'h80, 8'h02, 8'h01, 8'h02}; add_csum(); send(1'b0);
    step(1'b0, 8'h00); step(1'b0, 8'h00);

    scen = "data_wrap";
    fr = '{8'h1F, 8'h02, 8'h0F, 8'hAA}; add_csum(); send(1'b0);
    step(1'b0, 8'h00);

    scen = "len_zero";
    fr = '{8'h00, 8'h00}; send(1'b0); idle(3); do_reset();

    scen = "len_33";
    fr = '{8'h81, 8'h21}; send(1'b0); idle(3); do_reset();

    scen = "load_while_run";
    fr = '{8'hFF, 8'h00, 8'hFE}; send(1'b0); idle(2); do_reset();

    scen = "midframe_reset";
    fr = '{8'h03, 8'h03, 8'hAB}; send(1'b0); do_reset();
    fr = '{8'h05, 8'h01, 8'h33}; add_csum(); send(1'b0);
    step(1'b0, 8'h00);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    scen = "bad_checksum";
    fr = '{8'h00, 8'h01, 8'h11, 8'h00}; send(1'b0); idle(2); do_reset();
`endif

    scen = "random";
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 19);
      if (r < 12) begin
        if (e_run) step(1'b1, 8'hFE);
        cmd = {1'($urandom), 2'b00, 5'($urandom)};
        len = $urandom_range(1, 32);
        fr = '{cmd, 8'(len)};
        for (int k = 0; k < len; k++) fr.push_back(8'($urandom));
        add_csum();
        send(1'b1);
      end else if (r == 12) begin
        step(1'b1, 8'hFF);
      end else if (r == 13) begin
        step(1'b1, 8'hFE);
      end else if (r < 17) begin
        case ($urandom_range(0, 2))
          0: fr = '{{1'b0, 2'($urandom_range(1, 2)), 5'($urandom)}};
          1: fr = '{8'h04, 8'($urandom_range(33, 255))};
          default: fr = '{8'hFF, {1'($urandom), 2'b00, 5'($urandom)}};
        endcase
        send(1'b1);
        idle(2);
      end else begin
        fr = '{8'h40 ^ 8'h40, 8'h05, 8'($urandom)};
        send(1'b1);
        do_reset();
      end
      step(1'b0, 8'h00);
      if (m_err) do_reset();
    end
    step(1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
